counter_mod: RTL
================

COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 selects wrap-around at boundaries, 1 selects hold at boundaries.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 en  input  1  count enable; 0 holds all state, except that reset still acts.
REQ-006 control  input  2  operation: 0 clear, 1 count up, 2 count down, 3 load.
REQ-007 load  input  WIDTH  value written on the load operation.
REQ-008 limit  input  WIDTH  inclusive upper bound of the count range [0, limit].
REQ-009 count  output  WIDTH  registered counter value.
REQ-010 wrap  output  1  registered one-cycle pulse, high in the cycle after a boundary crossing in wrap mode.
REQ-011 sat  output  1  registered level, high while a boundary hold is in effect in saturate mode.
REQ-012 ovf  output  1  registered sticky flag, set by any boundary event (wrap or hold) or by a clamped load.

Function
REQ-013 All state changes occur only on the rising edge of clk; there is no combinational path from inputs to outputs.
REQ-014 en=0: count, ovf and sat hold their values; wrap is 0 in the next cycle.
REQ-015 en=1, control=0: count<=0, ovf<=0, sat<=0, wrap<=0.
REQ-016 en=1, control=1, count<limit: count<=count+1, sat<=0.
REQ-017 en=1, control=1, count>=limit, SATURATE=0: count<=0, wrap<=1, ovf<=1.
REQ-018 en=1, control=1, count>=limit, SATURATE=1: count<=limit, sat<=1, ovf<=1, wrap stays 0.
REQ-019 en=1, control=2, count>0: count<=count-1, sat<=0; this applies even when count>limit.
REQ-020 en=1, control=2, count==0, SATURATE=0: count<=limit, wrap<=1, ovf<=1.
REQ-021 en=1, control=2, count==0, SATURATE=1: count stays 0, sat<=1, ovf<=1.
REQ-022 en=1, control=3, load<=limit: count<=load, sat<=0.
REQ-023 en=1, control=3, load>limit: count<=limit (clamped), ovf<=1, sat<=0.
REQ-024 wrap is deasserted in every cycle that is not directly after a wrap event; back-to-back wraps give consecutive high cycles.
REQ-025 limit is sampled every cycle with no latching; a limit change below the current count takes effect on the next up operation (REQ-017/018).
REQ-026 limit=0: up and down operations both behave as boundary events, and count remains 0.
REQ-027 All arithmetic is unsigned modulo 2^WIDTH; count never exceeds limit except when limit is lowered under it.
REQ-028 Once set, ovf clears only on reset or on control=0 with en=1.

Reset
REQ-029 When reset=1 at a rising edge: count<=0, wrap<=0, sat<=0, ovf<=0, regardless of en, control, load and limit.
REQ-030 Reset takes priority over every operation; reset asserted mid-count abandons the operation, and counting resumes from 0 in the first cycle after reset deasserts.
REQ-031 All outputs are 0 in the first cycle after reset.

Verification (WIDTH=8)
REQ-032 SATURATE=0, limit=9, en=1, control=1 for 12 cycles from reset -> count 1..9, 0, 1, 2; wrap high only in the cycle count returns to 0; ovf=1 from then on.
REQ-033 SATURATE=1, limit=9, count up for 12 cycles -> count holds 9; sat=1 and ovf=1 from the 10th cycle; wrap is never asserted.
REQ-034 SATURATE=0, limit=9, count=0, control=2 -> count=9 and wrap pulses; control=0 next cycle -> count=0, ovf=0.
REQ-035 limit=9, control=3, load=200 -> count=9, ovf=1; then load=5 -> count=5; then en=0 with control=1 for 3 cycles -> count stays 5.
REQ-036 Count up to 7, then lower limit to 4 -> next up gives count=0 with a wrap pulse (SATURATE=0); count=7 with control=2 instead gives 6.
REQ-037 Assert reset during counting with control=1 held -> count=0 and all flags 0 the next cycle; after reset deasserts, count reads 1.

Source files
------------

// File: rtl/counter_mod.sv
// Up/down/load counter over the range [0, limit] with either wrap-around or
// hold-at-boundary behaviour, plus wrap pulse, saturation level and sticky overflow.
module counter_mod #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] load,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             sat,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_LOAD  = 2'd3
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             sat_d;
    logic             ovf_d;
    logic             at_top;
    logic             at_bottom;

    assign op        = op_e'(control);
    // count may sit above limit after limit is lowered; that still counts as the top boundary
    assign at_top    = (count >= limit);
    assign at_bottom = (count == '0);

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        sat_d   = sat;
        ovf_d   = ovf;
        if (en) begin
            case (op)
                OP_CLEAR: begin
                    count_d = '0;
                    sat_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_UP: begin
                    if (!at_top) begin
                        count_d = count + WIDTH'(1);
                        sat_d   = 1'b0;
                    end else if (SATURATE) begin
                        count_d = limit;
                        sat_d   = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                        sat_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end
                end
                OP_DOWN: begin
                    if (!at_bottom) begin
                        count_d = count - WIDTH'(1);
                        sat_d   = 1'b0;
                    end else if (SATURATE) begin
                        sat_d   = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = limit;
                        wrap_d  = 1'b1;
                        sat_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end
                end
                OP_LOAD: begin
                    sat_d = 1'b0;
                    if (load > limit) begin
                        count_d = limit;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = load;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
            sat   <= sat_d;
            ovf   <= ovf_d;
        end
    end

endmodule
